// File: rtl/cdb_arbiter_if.sv
// Bundle of the three FU result ports, the flush input and the common-data-bus broadcast.
// The arbiter connects through the slave modport; the FU/consumer side uses master.
interface cdb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) ();
    logic              flush;
    logic              fu0_valid;
    logic [TAG_W-1:0]  fu0_tag;
    logic [DATA_W-1:0] fu0_value;
    logic              fu0_ready;
    logic              fu1_valid;
    logic [TAG_W-1:0]  fu1_tag;
    logic [DATA_W-1:0] fu1_value;
    logic              fu1_ready;
    logic              fu2_valid;
    logic [TAG_W-1:0]  fu2_tag;
    logic [DATA_W-1:0] fu2_value;
    logic              fu2_ready;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic [1:0]        cdb_src;
    logic [7:0]        drop_count;

    modport master (
        output flush,
        output fu0_valid, fu0_tag, fu0_value,
        output fu1_valid, fu1_tag, fu1_value,
        output fu2_valid, fu2_tag, fu2_value,
        input  fu0_ready, fu1_ready, fu2_ready,
        input  cdb_valid, cdb_tag, cdb_value, cdb_src, drop_count
    );

    modport slave (
        input  flush,
        input  fu0_valid, fu0_tag, fu0_value,
        input  fu1_valid, fu1_tag, fu1_value,
        input  fu2_valid, fu2_tag, fu2_value,
        output fu0_ready, fu1_ready, fu2_ready,
        output cdb_valid, cdb_tag, cdb_value, cdb_src, drop_count
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, round-robin grant,
// registered one-cycle broadcast, tag-0 results dropped and counted.
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);

    function automatic logic [7:0] sat_add8(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    logic [2:0]        w_valid;
    logic [TAG_W-1:0]  w_tag   [3];
    logic [DATA_W-1:0] w_value [3];
    logic [2:0]        w_gnt;
    logic              w_gnt_any;
    logic [1:0]        w_gnt_idx;
    logic [2:0]        w_ready;
    logic [2:0]        w_xfer;
    logic [2:0]        w_fill;
    logic [2:0]        w_drop;
    logic [1:0]        w_ndrop;

    logic [2:0]        r_full;
    logic [TAG_W-1:0]  r_tag   [3];
    logic [DATA_W-1:0] r_value [3];
    logic [1:0]        r_rr;
    logic [7:0]        r_drop;
    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_value;
    logic [1:0]        r_cdb_src;

    assign w_valid    = {bus.fu2_valid, bus.fu1_valid, bus.fu0_valid};
    assign w_tag[0]   = bus.fu0_tag;
    assign w_tag[1]   = bus.fu1_tag;
    assign w_tag[2]   = bus.fu2_tag;
    assign w_value[0] = bus.fu0_value;
    assign w_value[1] = bus.fu1_value;
    assign w_value[2] = bus.fu2_value;

    // Walk the search order backwards so the slot closest to r_rr wins.
    always_comb begin
        int j;
        j         = 0;
        w_gnt_any = 1'b0;
        w_gnt_idx = r_rr;
        for (int i = 2; i >= 0; i--) begin
            j = (int'(r_rr) + i) % 3;
            if (r_full[j]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = 2'(j);
            end
        end
    end

    assign w_gnt   = w_gnt_any ? (3'b001 << w_gnt_idx) : 3'b000;
    assign w_ready = bus.flush ? 3'b000 : (~r_full | w_gnt);
    assign w_xfer  = w_valid & w_ready;

    always_comb begin
        w_fill = 3'b000;
        for (int n = 0; n < 3; n++) begin
            w_fill[n] = w_xfer[n] && (w_tag[n] != '0);
        end
    end

    assign w_drop  = w_xfer & ~w_fill;
    assign w_ndrop = {1'b0, w_drop[0]} + {1'b0, w_drop[1]} + {1'b0, w_drop[2]};

    // Control state and broadcast register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full      <= 3'b000;
            r_rr        <= 2'd0;
            r_drop      <= 8'd0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_value <= '0;
            r_cdb_src   <= 2'd0;
        end else if (bus.flush) begin
            r_full      <= 3'b000;
            r_cdb_valid <= 1'b0;
        end else begin
            r_full      <= (r_full & ~w_gnt) | w_fill;
            r_drop      <= sat_add8(r_drop, w_ndrop);
            r_cdb_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_cdb_tag   <= r_tag[w_gnt_idx];
                r_cdb_value <= r_value[w_gnt_idx];
                r_cdb_src   <= w_gnt_idx;
                r_rr        <= (w_gnt_idx == 2'd2) ? 2'd0 : w_gnt_idx + 2'd1;
            end
        end
    end

    // Slot payload is qualified by r_full, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (w_fill[n]) begin
                r_tag[n]   <= w_tag[n];
                r_value[n] <= w_value[n];
            end
        end
    end

    assign bus.fu0_ready  = w_ready[0];
    assign bus.fu1_ready  = w_ready[1];
    assign bus.fu2_ready  = w_ready[2];
    assign bus.cdb_valid  = r_cdb_valid;
    assign bus.cdb_tag    = r_cdb_tag;
    assign bus.cdb_value  = r_cdb_value;
    assign bus.cdb_src    = r_cdb_src;
    assign bus.drop_count = r_drop;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic, every cycle compared
// against a behavioural slot/round-robin model.
module tb_cdb_arbiter;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;

    logic clk;
    logic rst;

    cdb_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Stimulus for the next cycle
    logic              iv  [3];
    logic [TAG_W-1:0]  it  [3];
    logic [DATA_W-1:0] id  [3];
    logic              ifl;

    // Behavioural model: each FU owns a holding place that is either empty or has one result
    int                m_cnt [3];
    logic [TAG_W-1:0]  m_tag [3];
    logic [DATA_W-1:0] m_val [3];
    int                m_rr;
    int                m_drop;
    logic              e_valid;
    logic [TAG_W-1:0]  e_tag;
    logic [DATA_W-1:0] e_val;
    int                e_src;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            m_cnt[n] = 0;
            m_tag[n] = '0;
            m_val[n] = '0;
        end
        m_rr    = 0;
        m_drop  = 0;
        e_valid = 1'b0;
        e_tag   = '0;
        e_val   = '0;
        e_src   = 0;
    endtask

    // Winner this cycle: first occupied FU when counting from the rotating pointer; -1 if none.
    function automatic int model_winner();
        for (int off = 0; off < 3; off++) begin
            if (m_cnt[(m_rr + off) % 3] != 0) return (m_rr + off) % 3;
        end
        return -1;
    endfunction

    function automatic logic model_ready(input int n);
        if (ifl) return 1'b0;
        return (m_cnt[n] == 0) || (model_winner() == n);
    endfunction

    task automatic set_idle();
        for (int n = 0; n < 3; n++) begin
            iv[n] = 1'b0;
            it[n] = '0;
            id[n] = '0;
        end
        ifl = 1'b0;
    endtask

    task automatic drive_cycle();
        logic rdy [3];
        int   w;
        bus.flush     = ifl;
        bus.fu0_valid = iv[0]; bus.fu0_tag = it[0]; bus.fu0_value = id[0];
        bus.fu1_valid = iv[1]; bus.fu1_tag = it[1]; bus.fu1_value = id[1];
        bus.fu2_valid = iv[2]; bus.fu2_tag = it[2]; bus.fu2_value = id[2];
        #1;
        for (int n = 0; n < 3; n++) rdy[n] = model_ready(n);
        chk("fu0_ready", 64'(bus.fu0_ready), 64'(rdy[0]));
        chk("fu1_ready", 64'(bus.fu1_ready), 64'(rdy[1]));
        chk("fu2_ready", 64'(bus.fu2_ready), 64'(rdy[2]));
        w = model_winner();
        @(posedge clk);
        if (ifl) begin
            for (int n = 0; n < 3; n++) m_cnt[n] = 0;
            e_valid = 1'b0;
        end else begin
            if (w >= 0) begin
                e_valid  = 1'b1;
                e_tag    = m_tag[w];
                e_val    = m_val[w];
                e_src    = w;
                m_cnt[w] = 0;
                m_rr     = (w + 1) % 3;
            end else begin
                e_valid = 1'b0;
            end
            for (int n = 0; n < 3; n++) begin
                if (iv[n] && rdy[n]) begin
                    if (it[n] == 0) begin
                        m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
                    end else begin
                        m_cnt[n] = 1;
                        m_tag[n] = it[n];
                        m_val[n] = id[n];
                    end
                end
            end
        end
        @(negedge clk);
        chk("cdb_valid",  64'(bus.cdb_valid),  64'(e_valid));
        chk("cdb_tag",    64'(bus.cdb_tag),    64'(e_tag));
        chk("cdb_value",  64'(bus.cdb_value),  64'(e_val));
        chk("cdb_src",    64'(bus.cdb_src),    64'(e_src));
        chk("drop_count", 64'(bus.drop_count), 64'(m_drop));
    endtask

    task automatic check_zero_state(input string where);
        chk({where, "_valid"}, 64'(bus.cdb_valid),  64'd0);
        chk({where, "_tag"},   64'(bus.cdb_tag),    64'd0);
        chk({where, "_value"}, 64'(bus.cdb_value),  64'd0);
        chk({where, "_src"},   64'(bus.cdb_src),    64'd0);
        chk({where, "_drop"},  64'(bus.drop_count), 64'd0);
        chk({where, "_rdy"},   64'({bus.fu2_ready, bus.fu1_ready, bus.fu0_ready}), 64'h7);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        set_idle();
        bus.flush = 1'b0;
        bus.fu0_valid = 1'b0; bus.fu0_tag = '0; bus.fu0_value = '0;
        bus.fu1_valid = 1'b0; bus.fu1_tag = '0; bus.fu1_value = '0;
        bus.fu2_valid = 1'b0; bus.fu2_tag = '0; bus.fu2_value = '0;
        rst = 1'b1;
        model_reset();
        #12;
        check_zero_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single result from fu1
        iv[1] = 1'b1; it[1] = 4'd5; id[1] = 32'h0000_0014;
        drive_cycle();
        chk("single_early_valid", 64'(bus.cdb_valid), 64'd0);
        set_idle();
        drive_cycle();
        chk("single_valid", 64'(bus.cdb_valid), 64'd1);
        chk("single_tag",   64'(bus.cdb_tag),   64'd5);
        chk("single_value", 64'(bus.cdb_value), 64'h14);
        chk("single_src",   64'(bus.cdb_src),   64'd1);
        drive_cycle();
        chk("single_once", 64'(bus.cdb_valid), 64'd0);

        // Three-way contention after a fresh reset
        rst = 1'b1; #1; model_reset(); @(negedge clk); rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            iv[n] = 1'b1; it[n] = 4'(n + 1); id[n] = 32'(100 + n);
        end
        drive_cycle();
        set_idle();
        for (int c = 0; c < 3; c++) begin
            drive_cycle();
            chk("contend_src", 64'(bus.cdb_src), 64'(c));
            chk("contend_tag", 64'(bus.cdb_tag), 64'(c + 1));
        end
        drive_cycle();

        // Fairness: fu0 and fu2 offer every cycle
        for (int c = 0; c < 12; c++) begin
            iv[0] = 1'b1; it[0] = 4'(1 + (c % 15)); id[0] = 32'(c);
            iv[2] = 1'b1; it[2] = 4'(1 + ((c + 7) % 15)); id[2] = 32'(1000 + c);
            drive_cycle();
        end
        set_idle();
        for (int c = 0; c < 3; c++) drive_cycle();

        // Tag-0 results are discarded and counted, saturating
        iv[2] = 1'b1; it[2] = '0; id[2] = 32'hDEAD;
        drive_cycle();
        set_idle();
        drive_cycle();
        chk("drop_one_nobcast", 64'(bus.cdb_valid), 64'd0);
        iv[2] = 1'b1; it[2] = '0; id[2] = 32'hDEAD;
        for (int c = 0; c < 300; c++) drive_cycle();
        chk("drop_sat", 64'(bus.drop_count), 64'd255);
        set_idle();

        // Flush with all slots full
        for (int n = 0; n < 3; n++) begin
            iv[n] = 1'b1; it[n] = 4'(n + 9); id[n] = 32'(n + 55);
        end
        drive_cycle();
        set_idle();
        ifl = 1'b1;
        drive_cycle();
        ifl = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_cycle();
            chk("flush_quiet", 64'(bus.cdb_valid), 64'd0);
        end

        // Asynchronous reset pulse in the middle of a cycle with slots full
        for (int n = 0; n < 3; n++) begin
            iv[n] = 1'b1; it[n] = 4'(n + 3); id[n] = 32'(n + 77);
        end
        drive_cycle();
        set_idle();
        drive_cycle();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_zero_state("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_cycle();
            chk("post_rst_quiet", 64'(bus.cdb_valid), 64'd0);
        end

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            for (int n = 0; n < 3; n++) begin
                iv[n] = ($urandom_range(0, 9) < 7);
                it[n] = 4'($urandom_range(0, 15));
                id[n] = $urandom;
            end
            ifl = ($urandom_range(0, 19) == 0);
            drive_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: width of result values.
REQ-002 Parameter TAG_W, default 4: width of reservation-station destination tags; tag 0 is reserved as "no producer".
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous squash of all pending results (branch/exception recovery).
REQ-006 fuN_valid  input  1  (N=0,1,2; F0 add/sub, F1 mul/div, F2 load) result offered.
REQ-007 fuN_tag  input  TAG_W  destination tag of the offered result.
REQ-008 fuN_value  input  DATA_W  offered result value.
REQ-009 fuN_ready  output  1  holding slot N can accept a result this cycle.
REQ-010 cdb_valid  output  1  broadcast valid, registered.
REQ-011 cdb_tag  output  TAG_W  broadcast tag, registered.
REQ-012 cdb_value  output  DATA_W  broadcast value, registered.
REQ-013 cdb_src  output  2  index of the FU whose result is broadcast (0..2), registered.
REQ-014 drop_count  output  8  count of results discarded for tag 0, saturating.

Function
REQ-015 The block SHALL hold one single-entry slot per FU (full flag, tag, value).
REQ-016 A transfer on FU N SHALL occur at a rising edge where fuN_valid and fuN_ready are both 1; the slot then loads tag and value and sets full.
REQ-017 fuN_ready SHALL be 1 when slot N is empty or slot N is granted in the current cycle, and 0 during flush; it is combinational from slot state and grant only, never from fuN_valid.
REQ-018 A transfer carrying tag 0 SHALL NOT fill the slot; drop_count increments by 1, saturating at 255.
REQ-019 Each cycle the arbiter SHALL grant at most one full slot, using round-robin priority starting at pointer rr (0..2) and searching rr, rr+1, rr+2 mod 3.
REQ-020 On a grant to slot k, at the next edge: cdb_valid=1, cdb_tag/cdb_value=slot k contents, cdb_src=k, slot k clears unless refilled by a simultaneous transfer, and rr=(k+1) mod 3.
REQ-021 With no full slot, the next edge SHALL set cdb_valid=0, hold cdb_tag/cdb_value/cdb_src unchanged, and leave rr unchanged.
REQ-022 Latency: a result transferred at edge E into an empty, highest-priority slot SHALL appear on the CDB during the cycle after edge E+1; each broadcast lasts exactly one cycle.
REQ-023 Sustained throughput SHALL be one broadcast per cycle; a single FU presenting a result every cycle SHALL be accepted every cycle when no other slot is full.
REQ-024 Simultaneous grant and refill of the same slot SHALL broadcast the old contents and retain the new contents with full=1.
REQ-025 A slot's contents SHALL be broadcast unchanged, never duplicated, never reordered relative to later results of the same FU.
REQ-026 When flush=1 at an edge, all slots SHALL clear, no transfer SHALL be accepted, cdb_valid SHALL be 0 at that edge, and rr and drop_count are held.

Reset
REQ-027 While rst=1, regardless of clk: all slots empty, cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0, rr=0, drop_count=0, fuN_ready=1 for all N.
REQ-028 Reset asserted mid-operation SHALL discard pending results without broadcasting them; the first edge after deassertion behaves as a cycle from empty state.

Verification
REQ-029 Single result: fu1 offers tag 5, value 0x0000_0014 at edge E -> cdb_valid=1, tag 5, value 0x14, src 1 after edge E+1 only; fu1_ready stays 1.
REQ-030 Three-way contention after reset: all FUs offer tags 1,2,3 at the same edge -> broadcasts in src order 0,1,2 on three consecutive cycles; fu0_ready back to 1 in the cycle its slot is granted.
REQ-031 Fairness: fu0 and fu2 offer continuously with incrementing tags -> broadcasts alternate src 0,2,0,2; no src waits more than 2 cycles.
REQ-032 Tag 0: fu2 offers tag 0 value 0xDEAD -> no broadcast, drop_count=1; 300 such offers -> drop_count=255.
REQ-033 Flush and reset: fill all three slots, assert flush one cycle -> no broadcasts follow and all ready=1; repeat with async rst pulse mid-cycle -> outputs zero immediately, no stale broadcast after release.
